seg7_scan_reader: RTL and testbench

- Receiving end of the board's 7-segment display path: observes a multiplexed, active-low segment bus plus one-hot digit select, as driven by our hex-to-segment decoder and digit scanner.
- Debounces each digit slot and maps segment patterns back to 4-bit hex codes.
- Assembles a full frame of NDIG digits and publishes it atomically.
- Used for loopback self-test of display logic and for on-board verification.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_to_hex.sv | 40 ++++
 rtl/seg7_scan_reader.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_reader.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: bit order, active-low glyph constants and
// the reader FSM state type.
package seg7_pkg;

  // Bit positions within a {a,b,c,d,e,f,g} segment word.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Active-low glyphs: 0 = lit.
  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_A_HEX = 7'h08;
  localparam logic [6:0] SEG_B_HEX = 7'h60;
  localparam logic [6:0] SEG_C_HEX = 7'h31;
  localparam logic [6:0] SEG_D_HEX = 7'h42;
  localparam logic [6:0] SEG_E_HEX = 7'h30;
  localparam logic [6:0] SEG_F_HEX = 7'h38;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PUBLISH
  } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-segment decoder: active-low segment
// word to hex code, with blank and unrecognised-pattern flags.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       blank,
  output logic       err
);

  // NOTE: every output gets a default first so no path through the case
  // leaves a value unassigned, which would infer a latch.
  always_comb begin
    code  = 4'h0;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_A_HEX: code = 4'hA;
      SEG_B_HEX: code = 4'hB;
      SEG_C_HEX: code = 4'hC;
      SEG_D_HEX: code = 4'hD;
      SEG_E_HEX: code = 4'hE;
      SEG_F_HEX: code = 4'hF;
      SEG_BLANK: blank = 1'b1;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Observes a multiplexed 7-segment bus, debounces each digit dwell and
// publishes a complete decoded frame atomically.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] hex_out,
  output logic [NDIG-1:0]   blank_mask,
  output logic [NDIG-1:0]   err_mask,
  output logic              frame_valid,
  output logic              busy
);

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  state_t              state;
  logic [NDIG-1:0]     sel_q, sel_p;
  logic [6:0]          seg_q, seg_p;
  logic [3:0]          cnt, cnt_nxt;
  logic                same, sel_onehot, cap_now;
  logic [3:0]          dec_code;
  logic                dec_blank, dec_err;

  logic [4*NDIG-1:0]   sh_hex;
  logic [NDIG-1:0]     sh_blank, sh_err, captured;

  // Capture that qualified during PUBLISH, applied on the following IDLE cycle.
  logic                pend_v, pend_blank, pend_err;
  logic [NDIG-1:0]     pend_sel;
  logic [3:0]          pend_code;

  logic                cap_v, cap_blank, cap_err;
  logic [NDIG-1:0]     cap_sel;
  logic [3:0]          cap_code;

  seg7_to_hex u_dec (
    .seg   (seg_q),
    .code  (dec_code),
    .blank (dec_blank),
    .err   (dec_err)
  );

  assign same       = (sel_q == sel_p) && (seg_q == seg_p);
  assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - NDIG'(1))) == '0);

  // Capture fires only on the cycle the count first lands on STABLE, so a
  // long dwell yields exactly one capture.
  always_comb begin
    cnt_nxt = '0;
    cap_now = 1'b0;
    if (sel_onehot) begin
      if (same) cnt_nxt = (cnt == STABLE_C) ? cnt : cnt + 4'd1;
      else      cnt_nxt = 4'd1;
      cap_now = (cnt_nxt == STABLE_C) && !(same && (cnt == STABLE_C));
    end
  end

  assign cap_v     = pend_v | cap_now;
  assign cap_sel   = pend_v ? pend_sel   : sel_q;
  assign cap_code  = pend_v ? pend_code  : dec_code;
  assign cap_blank = pend_v ? pend_blank : dec_blank;
  assign cap_err   = pend_v ? pend_err   : dec_err;

  assign busy = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the shadow frame is small and held in flops, so it is reset along
  // with the control state; a partial frame must never survive rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel_q       <= '0;
      seg_q       <= '0;
      sel_p       <= '0;
      seg_p       <= '0;
      cnt         <= '0;
      sh_hex      <= '0;
      sh_blank    <= '0;
      sh_err      <= '0;
      captured    <= '0;
      pend_v      <= 1'b0;
      pend_sel    <= '0;
      pend_code   <= '0;
      pend_blank  <= 1'b0;
      pend_err    <= 1'b0;
      hex_out     <= '0;
      blank_mask  <= '0;
      err_mask    <= '0;
      frame_valid <= 1'b0;
    end else begin
      sel_q       <= dig_sel;
      seg_q       <= seg_in;
      sel_p       <= sel_q;
      seg_p       <= seg_q;
      cnt         <= cnt_nxt;
      frame_valid <= 1'b0;

      if (cap_v && (state != ST_PUBLISH)) begin
        for (int k = 0; k < NDIG; k++) begin
          if (cap_sel[k]) begin
            sh_hex[4*k +: 4] <= cap_code;
            sh_blank[k]      <= cap_blank;
            sh_err[k]        <= cap_err;
            captured[k]      <= 1'b1;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          pend_v <= 1'b0;
          if (cap_v) state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (captured == '1) state <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          hex_out     <= sh_hex;
          blank_mask  <= sh_blank;
          err_mask    <= sh_err;
          frame_valid <= 1'b1;
          captured    <= '0;
          state       <= ST_IDLE;
          if (cap_now) begin
            pend_v     <= 1'b1;
            pend_sel   <= sel_q;
            pend_code  <= dec_code;
            pend_blank <= dec_blank;
            pend_err   <= dec_err;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (NDIG=4, STABLE=3).
module tb_seg7_scan_reader;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [6:0]        seg_in;
  logic [NDIG-1:0]   dig_sel;
  logic [4*NDIG-1:0] hex_out;
  logic [NDIG-1:0]   blank_mask, err_mask;
  logic              frame_valid, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int fv_cyc = 0;
  int last_start = 0;
  logic busy_seen = 1'b0;
  int fv_before;

  seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .hex_out     (hex_out),
    .blank_mask  (blank_mask),
    .err_mask    (err_mask),
    .frame_valid (frame_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold one bus value for n cycles, observing outputs on each falling edge.
  task automatic drive(input logic [NDIG-1:0] sel, input logic [6:0] seg, input int n);
    dig_sel = sel;
    seg_in  = seg;
    repeat (n) begin
      @(negedge clk);
      if (frame_valid) begin
        fv_cnt++;
        fv_cyc = cyc;
      end
      if (busy) busy_seen = 1'b1;
    end
  endtask

  task automatic scan(input logic [6:0] s0, s1, s2, s3, input int n);
    drive(4'b0001, s0, n);
    drive(4'b0010, s1, n);
    drive(4'b0100, s2, n);
    last_start = cyc;
    drive(4'b1000, s3, n);
    drive(4'b0000, 7'h7F, 8);
  endtask

  initial begin
    rst     = 1'b1;
    dig_sel = '0;
    seg_in  = 7'h7F;
    repeat (2) @(negedge clk);
    check("reset_hex", 32'(hex_out), 32'h0);
    check("reset_blank", 32'(blank_mask), 32'h0);
    check("reset_err", 32'(err_mask), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: basic frame
    fv_before = fv_cnt;
    scan(7'h06, 7'h4C, 7'h24, 7'h20, 5);
    check("t1_frames", 32'(fv_cnt - fv_before), 32'd1);
    check("t1_hex", 32'(hex_out), 32'h6543);
    check("t1_blank", 32'(blank_mask), 32'h0);
    check("t1_err", 32'(err_mask), 32'h0);
    check("t1_latency", 32'(fv_cyc - last_start - 1), 32'(1 + STABLE + 1));
    check("t1_busy_after", 32'(busy), 32'h0);

    // 2: dwells shorter than STABLE never capture; outputs hold
    fv_before = fv_cnt;
    busy_seen = 1'b0;
    scan(7'h01, 7'h4F, 7'h12, 7'h06, 2);
    check("t2_frames", 32'(fv_cnt - fv_before), 32'd0);
    check("t2_busy_seen", 32'(busy_seen), 32'h0);
    check("t2_hex_hold", 32'(hex_out), 32'h6543);

    // 3: blank and unrecognised patterns
    fv_before = fv_cnt;
    scan(7'h06, 7'h55, 7'h7F, 7'h4C, 5);
    check("t3_frames", 32'(fv_cnt - fv_before), 32'd1);
    check("t3_hex", 32'(hex_out), 32'h4003);
    check("t3_blank", 32'(blank_mask), 32'b0100);
    check("t3_err", 32'(err_mask), 32'b0010);

    // 4: one-cycle glitch restarts the dwell on digit 0
    fv_before = fv_cnt;
    drive(4'b0001, 7'h0F, 2);
    drive(4'b0001, 7'h00, 1);
    drive(4'b0001, 7'h0F, 5);
    drive(4'b0010, 7'h01, 5);
    drive(4'b0100, 7'h12, 5);
    drive(4'b1000, 7'h06, 5);
    drive(4'b0000, 7'h7F, 8);
    check("t4_frames", 32'(fv_cnt - fv_before), 32'd1);
    check("t4_digit0", 32'(hex_out[3:0]), 32'h7);
    check("t4_hex", 32'(hex_out), 32'h3207);
    check("t4_err", 32'(err_mask), 32'h0);

    // 5: multi-hot select is a scan gap
    fv_before = fv_cnt;
    busy_seen = 1'b0;
    drive(4'b0011, 7'h01, 10);
    check("t5_gap_busy", 32'(busy_seen), 32'h0);
    scan(7'h01, 7'h4F, 7'h12, 7'h06, 5);
    check("t5_frames", 32'(fv_cnt - fv_before), 32'd1);
    check("t5_hex", 32'(hex_out), 32'h3210);

    // 6: asynchronous reset mid-frame
    drive(4'b0001, 7'h0F, 5);
    drive(4'b0010, 7'h00, 5);
    check("t6_busy_mid", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_hex", 32'(hex_out), 32'h0);
    check("t6_rst_blank", 32'(blank_mask), 32'h0);
    check("t6_rst_err", 32'(err_mask), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fv_before = fv_cnt;
    scan(7'h0F, 7'h00, 7'h08, 7'h60, 5);
    check("t6_frames", 32'(fv_cnt - fv_before), 32'd1);
    check("t6_hex", 32'(hex_out), 32'hBA87);
    check("t6_blank", 32'(blank_mask), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
